usb_packet_receiver: RTL and testbench
======================================

Name: usb_packet_receiver

Overview:
Downstream stage of the full-speed receive path (oversampler / NRZI decoder / bit unstuffer). Consumes one decoded, unstuffed bit per strobe plus the SE0/EOP level, and performs the following functions:
- hunts for SYNC, captures and checks the PID;
- assembles payload bytes LSB-first;
- runs CRC5 (tokens) and CRC16 (data packets);
- reports per-packet status to the protocol/endpoint logic.

Parameters:
- SYNC_PATTERN, 8'h80: shifter value (new bit enters at MSB) that marks end of SYNC.
- TIMEOUT_CLKS, 40: clocks without bitValid or EOP inside a packet before abort (4 bit times at 10x oversampling).
- MAX_BYTES, 1027: post-PID byte limit; exceeding it is an overflow error.

Ports:
- useClk, in, 1: receive clock (10x bit rate).
- rstN, in, 1: reset, asynchronous, active-low.
- bitValid, in, 1: one-clock strobe per decoded bit; stuffed bits are never strobed.
- bitData, in, 1: decoded bit, qualified by bitValid.
- eopDetect, in, 1: SE0/EOP level from the front end; the rising edge ends the packet.
- rxActive, out, 1: high from SYNC match until packet end.
- pidOut, out, 4: PID[3:0] of the current packet.
- pidValid, out, 1: one-clock pulse when PID is captured and checks good.
- rxByte, out, 8: payload byte, including CRC bytes.
- rxByteValid, out, 1: one-clock pulse per completed byte.
- byteCount, out, 11: post-PID bytes received in the current packet.
- pktDone, out, 1: one-clock pulse at end of every packet, including aborted packets.
- pktOk, out, 1: valid with pktDone; 1 = packet good.
- errFlags, out, 4: valid with pktDone and held until the next SYNC. Bit 0 = PID, bit 1 = CRC, bit 2 = alignment, bit 3 = timeout/overflow.

Behaviour:
- Reset (async, rstN=0): state IDLE; all outputs 0, including errFlags, byteCount and pidOut; shifter=0; CRC registers all ones. Reset mid-packet abandons it silently with no pktDone.
- eopDetect is registered once. eopRise = eop & ~eop_q.
- IDLE:
  - on bitValid, shifter <= {bitData, shifter[7:1]};
  - when shifter == SYNC_PATTERN after the shift, go to PID: clear bitCnt, byteCount, errFlags; set rxActive=1; initialise CRC5=5'h1F and CRC16=16'hFFFF.
  - eopRise in IDLE is ignored.
- PID: collect 8 bits. On the 8th bit:
  - if pid[3:0] == ~pid[7:4]: pidOut <= pid[3:0]; pidValid pulses the next clock; go to DATA;
  - otherwise set errFlags[0] and go to WAIT_EOP.
- DATA: each bitValid shifts into the byte shifter and feeds both CRC LFSRs.
  - LFSR update per bit: fb = bitData ^ r[MSB]; r <= {r[MSB-1:0],0} ^ (fb ? POLY : 0).
  - POLY5 = 5'h05; POLY16 = 16'h8005.
  - On every 8th bit: rxByte, rxByteValid pulse, byteCount+1.
  - If byteCount would exceed MAX_BYTES: set errFlags[3], stop emitting bytes, go to WAIT_EOP.
- WAIT_EOP: ignore bits until eopRise.
- End of packet, on eopRise in PID, DATA or WAIT_EOP: go to DONE, which lasts one clock. In DONE: pktDone=1, rxActive drops, then return to IDLE with shifter=0. Checks in DATA:
  - bitCnt mod 8 != 0 sets errFlags[2];
  - token (pid[1:0]==01): requires byteCount==2 and CRC5 residual == 5'b01100, else errFlags[1];
  - data (pid[1:0]==11): requires byteCount>=2 and CRC16 residual == 16'h800D, else errFlags[1];
  - handshake (10): requires byteCount==0, else errFlags[2];
  - special (00): no CRC check.
  - pktOk = (errFlags == 0).
- eopRise in PID state gives errFlags[2] (short packet).
- Timeout: in PID, DATA or WAIT_EOP, an idle counter resets on any bitValid or eopRise. At TIMEOUT_CLKS: set errFlags[3] and go to DONE (pktOk=0).
- Simultaneous bitValid and eopRise: EOP wins; that bit is discarded.
- Latency: rxByteValid / pidValid assert 1 clock after the completing bitValid. pktDone asserts 1 clock after eopRise.

Optional Feature:
- Macro: USB_CRC16_CHECK_EN.
- Defined: CRC16 LFSR instantiated; data-packet residual checked as above.
- Undefined: no CRC16 logic; data packets never set errFlags[1]. CRC5 and all other checks are unchanged.

Decomposition:
- Package usb_rx_pkg holds: PID codes, POLY5/POLY16, residual constants, state encoding (IDLE, PID, DATA, WAIT_EOP, DONE), errFlags bit indices.
- Sub-module usb_crc_lfsr, parameterised WIDTH/POLY/INIT, with serial input and enable. Instantiated for CRC5 and, under the macro, for CRC16.

Test Plan:
- SYNC, SETUP 2D 00 10, EOP: pidValid with pidOut=4'hD; rxByte 00 then 10; byteCount=2; pktOk=1; errFlags=0.
- SYNC, DATA0 C3 80 06 00 01 00 00 40 00 DD 94, EOP: 10 bytes out; pktOk=1. Same packet with last byte 95: errFlags[1]=1, pktOk=0 (macro defined); pktOk=1 with macro undefined.
- SYNC, ACK D2, EOP: pidOut=4'h2; byteCount=0; pktOk=1.
- SYNC, byte 2C (PID check fails), 16 more bits, EOP: no pidValid; no rxByteValid; pktDone with errFlags=4'b0001.
- SYNC, DATA1 4B, 13 bits, EOP: errFlags[2]=1. bitValid stopped for 40 clocks mid-DATA: pktDone with errFlags[3]=1.
- rstN pulsed low mid-DATA: all outputs 0 immediately, no pktDone. Next SYNC+ACK decodes normally.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: PID codes, CRC constants, FSM encoding and error-bit indices for the USB packet receiver.
package usb_rx_pkg;
  localparam logic [3:0] PID_OUT = 4'h1, PID_IN = 4'h9, PID_SOF = 4'h5, PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3, PID_DATA1 = 4'hB, PID_ACK = 4'h2, PID_NAK = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE, PID_PRE = 4'hC;
  localparam logic [1:0] PT_SPECIAL = 2'b00, PT_TOKEN = 2'b01, PT_HANDSHAKE = 2'b10, PT_DATA = 2'b11;
  localparam logic [4:0] POLY5 = 5'h05, CRC5_INIT = 5'h1F, CRC5_RESIDUAL = 5'h0C;
  localparam logic [15:0] POLY16 = 16'h8005, CRC16_INIT = 16'hFFFF, CRC16_RESIDUAL = 16'h800D;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_PID = 3'd1, ST_DATA = 3'd2, ST_WAIT_EOP = 3'd3, ST_DONE = 3'd4;
  localparam int ERR_PID = 0, ERR_CRC = 1, ERR_ALIGN = 2, ERR_TMO = 3;
endpackage

// File: rtl/usb_packet_receiver_if.sv
// usb_packet_receiver_if: decoded bit stream from the front end and per-packet results to the endpoint logic.
interface usb_packet_receiver_if;
  logic bitValid, bitData, eopDetect;
  logic rxActive, pidValid, rxByteValid, pktDone, pktOk;
  logic [3:0] pidOut, errFlags;
  logic [7:0] rxByte;
  logic [10:0] byteCount;
  modport master (
    output bitValid, bitData, eopDetect,
    input rxActive, pidOut, pidValid, rxByte, rxByteValid, byteCount, pktDone, pktOk, errFlags
  );
  modport slave (
    input bitValid, bitData, eopDetect,
    output rxActive, pidOut, pidValid, rxByte, rxByteValid, byteCount, pktDone, pktOk, errFlags
  );
endinterface

// File: rtl/usb_crc_lfsr.sv
// usb_crc_lfsr: serial CRC register, MSB feedback, with synchronous reload to INIT.
module usb_crc_lfsr #(
  parameter int WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY = '0,
  parameter logic [WIDTH-1:0] INIT = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic en,
  input  logic din,
  output logic [WIDTH-1:0] crc
);
  logic [WIDTH-1:0] crc_q, crc_d;
  logic fb;
  always_comb begin
    fb = din ^ crc_q[WIDTH-1];
    crc_d = init ? INIT : en ? ({crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0)) : crc_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc_q <= INIT;
    else crc_q <= crc_d;
  assign crc = crc_q;
endmodule

// File: rtl/usb_packet_receiver.sv
// usb_packet_receiver: SYNC hunt, PID check, LSB-first byte assembly and CRC5/CRC16 packet status.
// Define USB_CRC16_CHECK_EN to build the CRC16 residual check for data packets.
module usb_packet_receiver
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int TIMEOUT_CLKS = 40,
  parameter int MAX_BYTES = 1027
) (
  input logic useClk,
  input logic rstN,
  usb_packet_receiver_if.slave rx
);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [2:0] state_q, state_d;
  logic [7:0] shifter_q, shifter_d;
  logic eop_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [10:0] byte_count_q, byte_count_d;
  logic [3:0] err_q, err_d, pid_q, pid_d;
  logic pid_valid_q, pid_valid_d, rx_byte_valid_q, rx_byte_valid_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [TW-1:0] idle_q, idle_d;
  logic eop_rise, bit_in, in_pkt, sync_hit, crc_en, timeout, crc16_bad;
  logic [7:0] shifted;
  logic [4:0] crc5;

  assign eop_rise = rx.eopDetect & ~eop_q;
  // a bit arriving with the EOP edge is dropped
  assign bit_in = rx.bitValid & ~eop_rise;
  assign shifted = {rx.bitData, shifter_q[7:1]};
  assign in_pkt = state_q inside {ST_PID, ST_DATA, ST_WAIT_EOP};
  assign sync_hit = state_q == ST_IDLE && rx.bitValid && shifted == SYNC_PATTERN;
  assign crc_en = state_q == ST_DATA && bit_in;
  assign timeout = in_pkt && !bit_in && !eop_rise && idle_q == TW'(TIMEOUT_CLKS - 1);

  usb_crc_lfsr #(.WIDTH(5), .POLY(POLY5), .INIT(CRC5_INIT)) u_crc5 (
    .clk(useClk), .rst_n(rstN), .init(sync_hit), .en(crc_en), .din(rx.bitData), .crc(crc5)
  );
`ifdef USB_CRC16_CHECK_EN
  logic [15:0] crc16;
  usb_crc_lfsr #(.WIDTH(16), .POLY(POLY16), .INIT(CRC16_INIT)) u_crc16 (
    .clk(useClk), .rst_n(rstN), .init(sync_hit), .en(crc_en), .din(rx.bitData), .crc(crc16)
  );
  assign crc16_bad = byte_count_q < 11'd2 || crc16 != CRC16_RESIDUAL;
`else
  assign crc16_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shifter_d = shifter_q;
    bit_cnt_d = bit_cnt_q;
    byte_count_d = byte_count_q;
    err_d = err_q;
    pid_d = pid_q;
    pid_valid_d = 1'b0;
    rx_byte_d = rx_byte_q;
    rx_byte_valid_d = 1'b0;
    idle_d = (bit_in || eop_rise) ? '0 : idle_q + 1'b1;
    if (timeout) begin
      err_d[ERR_TMO] = 1'b1;
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idle_d = '0;
          if (rx.bitValid) shifter_d = shifted;
          if (sync_hit) begin
            state_d = ST_PID;
            bit_cnt_d = '0;
            byte_count_d = '0;
            err_d = '0;
          end
        end
        ST_PID:
          if (eop_rise) begin
            err_d[ERR_ALIGN] = 1'b1;
            state_d = ST_DONE;
          end else if (bit_in) begin
            shifter_d = shifted;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              if (shifted[3:0] == ~shifted[7:4]) begin
                pid_d = shifted[3:0];
                pid_valid_d = 1'b1;
                state_d = ST_DATA;
              end else begin
                err_d[ERR_PID] = 1'b1;
                state_d = ST_WAIT_EOP;
              end
            end
          end
        ST_DATA:
          if (eop_rise) begin
            state_d = ST_DONE;
            if (bit_cnt_q != 3'd0) err_d[ERR_ALIGN] = 1'b1;
            if (pid_q[1:0] == PT_TOKEN && (byte_count_q != 11'd2 || crc5 != CRC5_RESIDUAL)) err_d[ERR_CRC] = 1'b1;
            if (pid_q[1:0] == PT_DATA && crc16_bad) err_d[ERR_CRC] = 1'b1;
            if (pid_q[1:0] == PT_HANDSHAKE && byte_count_q != 11'd0) err_d[ERR_ALIGN] = 1'b1;
          end else if (bit_in) begin
            shifter_d = shifted;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_count_q == 11'(MAX_BYTES)) begin
                err_d[ERR_TMO] = 1'b1;
                state_d = ST_WAIT_EOP;
              end else begin
                rx_byte_d = shifted;
                rx_byte_valid_d = 1'b1;
                byte_count_d = byte_count_q + 11'd1;
              end
            end
          end
        ST_WAIT_EOP: state_d = eop_rise ? ST_DONE : ST_WAIT_EOP;
        ST_DONE: begin
          state_d = ST_IDLE;
          shifter_d = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge useClk or negedge rstN)
    if (!rstN) begin
      state_q <= ST_IDLE;
      shifter_q <= '0;
      eop_q <= 1'b0;
      bit_cnt_q <= '0;
      byte_count_q <= '0;
      err_q <= '0;
      pid_q <= '0;
      pid_valid_q <= 1'b0;
      rx_byte_q <= '0;
      rx_byte_valid_q <= 1'b0;
      idle_q <= '0;
    end else begin
      state_q <= state_d;
      shifter_q <= shifter_d;
      eop_q <= rx.eopDetect;
      bit_cnt_q <= bit_cnt_d;
      byte_count_q <= byte_count_d;
      err_q <= err_d;
      pid_q <= pid_d;
      pid_valid_q <= pid_valid_d;
      rx_byte_q <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      idle_q <= idle_d;
    end

  assign rx.rxActive = in_pkt;
  assign rx.pidOut = pid_q;
  assign rx.pidValid = pid_valid_q;
  assign rx.rxByte = rx_byte_q;
  assign rx.rxByteValid = rx_byte_valid_q;
  assign rx.byteCount = byte_count_q;
  assign rx.pktDone = state_q == ST_DONE;
  assign rx.pktOk = state_q == ST_DONE && err_q == 4'd0;
  assign rx.errFlags = err_q;
endmodule

// File: tb/tb_usb_packet_receiver.sv
// tb_usb_packet_receiver: table vectors, directed corner sequences and random packets against a bit-level model.
module tb_usb_packet_receiver;
  typedef logic [7:0] bq_t[$];
  typedef bit bits_t[$];
  typedef struct {
    logic [7:0] pid;
    int n;
    logic [95:0] data;
    int nx;
    logic [7:0] xb;
    bit pidv;
    logic [3:0] err;
    logic [10:0] cnt;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  int total = 0, bad = 0, gap = 3, done_cnt = 0;
  bq_t pid_seen, bytes_seen;
  logic pkt_ok_seen;
  logic [3:0] err_seen;
  logic [10:0] cnt_seen;

  usb_packet_receiver_if rx_if ();
  usb_packet_receiver dut (.useClk(clk), .rstN(rst_n), .rx(rx_if));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_if.pidValid) pid_seen.push_back({4'h0, rx_if.pidOut});
    if (rx_if.rxByteValid) bytes_seen.push_back(rx_if.rxByte);
    if (rx_if.pktDone) begin
      done_cnt++;
      pkt_ok_seen = rx_if.pktOk;
      err_seen = rx_if.errFlags;
      cnt_seen = rx_if.byteCount;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] outs();
    return {rx_if.rxActive, rx_if.pidOut, rx_if.pidValid, rx_if.rxByte, rx_if.rxByteValid,
            rx_if.byteCount, rx_if.pktDone, rx_if.pktOk, rx_if.errFlags};
  endfunction

  function automatic int crc_res(input bits_t b, input int w, input int poly);
    int r;
    bit fb;
    r = (1 << w) - 1;
    foreach (b[i]) begin
      fb = b[i] ^ r[w-1];
      r = ((r << 1) & ((1 << w) - 1)) ^ (fb ? poly : 0);
    end
    return r;
  endfunction

  function automatic bits_t with_crc(input bits_t b, input int w, input int poly);
    bits_t o;
    int r;
    o = b;
    r = crc_res(b, w, poly);
    for (int k = w - 1; k >= 0; k--) o.push_back(~r[k]);
    return o;
  endfunction

  function automatic void model(input logic [7:0] pid, input bq_t pl, input int nx, input logic [7:0] xb,
                                output bit pidv, output logic [3:0] err);
    bits_t b;
    pidv = pid[3:0] == ~pid[7:4];
    err = pidv ? 4'h0 : 4'h1;
    foreach (pl[i]) for (int k = 0; k < 8; k++) b.push_back(pl[i][k]);
    for (int k = 0; k < nx; k++) b.push_back(xb[k]);
    if (pidv) begin
      if (nx % 8 != 0) err[2] = 1'b1;
      if (pid[1:0] == 2'b10 && pl.size() != 0) err[2] = 1'b1;
      if (pid[1:0] == 2'b01 && (pl.size() != 2 || crc_res(b, 5, 'h05) != 'h0C)) err[1] = 1'b1;
`ifdef USB_CRC16_CHECK_EN
      if (pid[1:0] == 2'b11 && (pl.size() < 2 || crc_res(b, 16, 'h8005) != 'h800D)) err[1] = 1'b1;
`endif
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tx_bit(input logic b);
    rx_if.bitValid = 1'b1;
    rx_if.bitData = b;
    @(posedge clk); #1;
    rx_if.bitValid = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic tx_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
  endtask

  task automatic tx_eop();
    rx_if.eopDetect = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rx_if.eopDetect = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] pid, input int npid, input bq_t pl, input int nx,
                          input logic [7:0] xb, input bit eop);
    pid_seen.delete();
    bytes_seen.delete();
    done_cnt = 0;
    tx_byte(8'h80);
    for (int i = 0; i < npid; i++) tx_bit(pid[i]);
    foreach (pl[i]) tx_byte(pl[i]);
    for (int i = 0; i < nx; i++) tx_bit(xb[i]);
    if (eop) tx_eop();
    for (int i = 0; i < 100 && done_cnt == 0; i++) begin @(posedge clk); #1; end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_pkt(input string tag, input bit pidv, input logic [3:0] pid, input bq_t exp,
                           input logic [3:0] err, input logic [10:0] cnt);
    int mis;
    mis = 0;
    check({tag, " pktDone count"}, done_cnt, 1);
    check({tag, " pidValid count"}, pid_seen.size(), {31'd0, pidv});
    if (pidv && pid_seen.size() > 0) check({tag, " pidOut"}, pid_seen[0], {28'd0, pid});
    check({tag, " byte pulses"}, bytes_seen.size(), exp.size());
    foreach (exp[i]) if (i < bytes_seen.size() && bytes_seen[i] !== exp[i]) mis++;
    check({tag, " byte mismatches"}, mis, 0);
    check({tag, " pktOk"}, {31'd0, pkt_ok_seen}, {31'd0, err == 4'd0});
    check({tag, " errFlags"}, {28'd0, err_seen}, {28'd0, err});
    check({tag, " byteCount"}, {21'd0, cnt_seen}, {21'd0, cnt});
  endtask

  vec_t tv[6];
  bq_t pl, exp;
  bits_t bb;
  logic [7:0] pid, xb;
  int kind, nx, nb;
  bit pidv;
  logic [3:0] err;

  initial begin
    rx_if.bitValid = 1'b0;
    rx_if.bitData = 1'b0;
    rx_if.eopDetect = 1'b0;
    tv[0] = '{8'h2D, 2, 96'h1000, 0, 8'h00, 1'b1, 4'h0, 11'd2};
    tv[1] = '{8'hC3, 10, 96'h94DD_0040_0000_0100_0680, 0, 8'h00, 1'b1, 4'h0, 11'd10};
`ifdef USB_CRC16_CHECK_EN
    tv[2] = '{8'hC3, 10, 96'h95DD_0040_0000_0100_0680, 0, 8'h00, 1'b1, 4'h2, 11'd10};
    tv[5] = '{8'h4B, 1, 96'h12, 5, 8'h15, 1'b1, 4'h6, 11'd1};
`else
    tv[2] = '{8'hC3, 10, 96'h95DD_0040_0000_0100_0680, 0, 8'h00, 1'b1, 4'h0, 11'd10};
    tv[5] = '{8'h4B, 1, 96'h12, 5, 8'h15, 1'b1, 4'h4, 11'd1};
`endif
    tv[3] = '{8'hD2, 0, 96'h0, 0, 8'h00, 1'b1, 4'h0, 11'd0};
    tv[4] = '{8'h2C, 2, 96'h5AA5, 0, 8'h00, 1'b0, 4'h1, 11'd0};

    repeat (3) begin @(posedge clk); #1; end
    check("reset outputs", outs(), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    foreach (tv[i]) begin
      pl.delete();
      exp.delete();
      for (int k = 0; k < tv[i].n; k++) pl.push_back(tv[i].data[8*k +: 8]);
      if (tv[i].pidv) exp = pl;
      send_pkt(tv[i].pid, 8, pl, tv[i].nx, tv[i].xb, 1'b1);
      check_pkt($sformatf("vec%0d", i), tv[i].pidv, tv[i].pid[3:0], exp, tv[i].err, tv[i].cnt);
    end

    pl.delete();
    exp.delete();
    send_pkt(8'hD2, 4, pl, 0, 8'h00, 1'b1);
    check_pkt("short pid", 1'b0, 4'h0, exp, 4'h4, 11'd0);

    done_cnt = 0;
    tx_eop();
    repeat (5) begin @(posedge clk); #1; end
    check("idle eop pktDone count", done_cnt, 0);

    pl.push_back(8'h11);
    exp = pl;
    send_pkt(8'hC3, 8, pl, 3, 8'h05, 1'b0);
    check_pkt("timeout", 1'b1, 4'h3, exp, 4'h8, 11'd1);
    check("timeout rxActive", {31'd0, rx_if.rxActive}, 32'd0);

    gap = 1;
    pl.delete();
    for (int i = 0; i < 1028; i++) pl.push_back(8'($urandom));
    exp = pl;
    void'(exp.pop_back());
    send_pkt(8'hC3, 8, pl, 0, 8'h00, 1'b1);
    check_pkt("overflow", 1'b1, 4'h3, exp, 4'h8, 11'd1027);

    gap = 2;
    done_cnt = 0;
    tx_byte(8'h80);
    tx_byte(8'hC3);
    tx_byte(8'hAA);
    for (int i = 0; i < 3; i++) tx_bit(1'b1);
    check("pre-reset rxActive", {31'd0, rx_if.rxActive}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("mid-packet reset outputs", outs(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("reset pktDone count", done_cnt, 0);
    pl.delete();
    exp.delete();
    send_pkt(8'hD2, 8, pl, 0, 8'h00, 1'b1);
    check_pkt("post-reset ack", 1'b1, 4'h2, exp, 4'h0, 11'd0);

    for (int r = 0; r < 40; r++) begin
      bb.delete();
      pl.delete();
      exp.delete();
      nx = 0;
      xb = 8'($urandom);
      gap = $urandom_range(1, 4);
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          pid = ($urandom_range(0, 2) == 0) ? 8'hE1 : ($urandom_range(0, 1) == 0) ? 8'h69 : 8'h2D;
          for (int k = 0; k < 11; k++) bb.push_back(1'($urandom));
          bb = with_crc(bb, 5, 'h05);
          if ($urandom_range(0, 7) == 0) for (int k = 0; k < 8; k++) bb.push_back(1'($urandom));
        end
        1: begin
          pid = $urandom_range(0, 1) ? 8'hC3 : 8'h4B;
          nb = $urandom_range(0, 12);
          for (int k = 0; k < 8 * nb; k++) bb.push_back(1'($urandom));
          bb = with_crc(bb, 16, 'h8005);
        end
        2: begin
          pid = $urandom_range(0, 1) ? 8'hD2 : 8'h5A;
          if ($urandom_range(0, 3) == 0) for (int k = 0; k < 8; k++) bb.push_back(1'($urandom));
        end
        3: begin
          pid = 8'h3C;
          nb = $urandom_range(0, 3);
          for (int k = 0; k < 8 * nb; k++) bb.push_back(1'($urandom));
        end
        default: begin
          pid = 8'($urandom);
          if (pid[3:0] == ~pid[7:4]) pid[4] = ~pid[4];
          nb = $urandom_range(0, 2);
          for (int k = 0; k < 8 * nb; k++) bb.push_back(1'($urandom));
        end
      endcase
      if (bb.size() > 0 && $urandom_range(0, 3) == 0) begin
        nb = $urandom_range(0, bb.size() - 1);
        bb[nb] = ~bb[nb];
      end
      if ($urandom_range(0, 4) == 0) nx = $urandom_range(1, 7);
      for (int k = 0; k < bb.size() / 8; k++) begin
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = bb[8*k + j];
        pl.push_back(v);
      end
      model(pid, pl, nx, xb, pidv, err);
      if (pidv) exp = pl;
      send_pkt(pid, 8, pl, nx, xb, 1'b1);
      check_pkt($sformatf("rand%0d pid %0h", r, pid), pidv, pid[3:0], exp, err,
                pidv ? 11'(pl.size()) : 11'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
